ula_aritmetica_seq: RTL and testbench
=====================================

Name: ula_aritmetica_seq

Overview:
- Parametrised, handshaked, multi-cycle successor to the 6-bit combinational arithmetic ALU.
- Adds generic WIDTH, optional saturation, negate, iterative unsigned multiply, carry/negative/illegal flags, and registered results.
- Sits between the operand register file and the datapath writeback.
- Accepts one operation at a time over a valid/ready handshake and holds each result until it is consumed.

Parameters:
WIDTH, 6, operand/result width in bits (>=2)
SAT_EN, 1, 1 = Sat input honoured; 0 = Sat treated as 0

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  reset, synchronous, active-high
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Sel  input  4  opcode
Sat  input  1  saturate result for this operation
out_valid  output  1  result registers valid
out_ready  input  1  consumer takes result
O  output  WIDTH  result
Carry  output  1  raw adder carry-out (inc/dec: wrap indicator)
Overflow  output  1  signed overflow (mul: product exceeds WIDTH bits)
Zero  output  1  O == 0
Negative  output  1  O[WIDTH-1]
Illegal  output  1  Sel was unassigned

Behaviour:
- Reset, sampled on Clk: state=IDLE; O=0; Carry, Overflow, Negative, Illegal, out_valid = 0; Zero=1.
- Reset aborts any in-progress MUL or unconsumed result; nothing is emitted for the aborted operation.
- FSM states: IDLE, MUL, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - Inputs are captured only on in_valid && in_ready. A, B, Sel and Sat are registered at acceptance; later changes are ignored.
- IDLE transitions:
  - Non-MUL opcode accepted: result and flags are computed and registered in the same edge; next state DONE (latency 1).
  - MUL accepted: load multiplicand, multiplier and a 2*WIDTH accumulator; next state MUL; iteration counter=0.
- MUL state:
  - One shift-add step per cycle, LSB first, for exactly WIDTH cycles.
  - On the last step, register O = product[WIDTH-1:0]; next state DONE.
  - out_valid rises WIDTH+1 cycles after acceptance.
- DONE state:
  - O and all flags are held stable while out_ready=0.
  - out_valid && out_ready: next state IDLE. in_ready returns the following cycle; a new op cannot be accepted in the handshake cycle.
- Add/sub family: R = X + Y + cin, computed at WIDTH+1 bits.
  - 0000 ADD: X=A, Y=B, cin=0
  - 0001 SUB: X=A, Y=~B, cin=1
  - 0010 ADD_NOTB: X=A, Y=~B, cin=0
  - 0011 SUB_NOTB: X=A, Y=B, cin=1
  - 1001 NEG: X=0, Y=~A, cin=1
  - Carry = R[WIDTH].
  - Overflow = (X[msb]==Y[msb]) && (R[msb]!=X[msb]).
  - Sat=1 and Overflow: O = X[msb] ? signed min (10..0) : signed max (01..1). Overflow stays 1.
- Inc/dec, unsigned:
  - 0100 INC A, 0101 DEC A, 0110 INC B, 0111 DEC B.
  - Carry=1 when incrementing all-ones or decrementing zero. Overflow=0.
  - Wraps when Sat=0; clamps (operand unchanged) when Sat=1.
- 1000 MUL, unsigned:
  - Overflow = |product[2W-1:W]. Carry=0.
  - Sat=1 and Overflow: O = all-ones.
- Zero and Negative are always derived from the final registered O, including after saturation.
- 1010..1111: O=0, Zero=1, Illegal=1, other flags 0; latency 1.
- Illegal=0 for every legal opcode.

Decomposition:
- Package ula_pkg:
  - opcode enum op_e (OP_ADD..OP_NEG)
  - state enum st_e
  - flags struct {carry, overflow, zero, negative, illegal}
- Sub-module ula_mul_iter:
  - Iterative shift-add multiplier with start/busy/done.
  - Parametrised by WIDTH.
  - Owned by ula_aritmetica_seq.
- The add/sub/inc/dec datapath stays inline as a function.

Test Plan (WIDTH=6, SAT_EN=1):
- ADD A=30, B=5, Sat=0 -> O=35 (100011), Overflow=1, Carry=0, Negative=1, Zero=0, out_valid one cycle after accept. Same with Sat=1 -> O=31, Overflow=1, Negative=0.
- SUB A=0, B=1 -> O=63, Carry=0, Overflow=0, Negative=1. SUB A=5, B=3 -> O=2, Carry=1. SUB_NOTB A=2, B=3 -> O=6.
- INC A=63, Sat=0 -> O=0, Carry=1, Zero=1. Sat=1 -> O=63, Carry=1, Zero=0. DEC B=0, Sat=1 -> O=0, Carry=1, Zero=1.
- MUL 7*9 -> O=63, Overflow=0, out_valid exactly 7 cycles after accept, in_ready=0 throughout. MUL 8*8, Sat=0 -> O=0, Overflow=1, Zero=1.
- Backpressure: hold out_ready=0 for 3 cycles after a result while toggling in_valid, A and B -> O and flags unchanged, in_ready=0, no new op accepted; release -> in_ready=1 on the next cycle.
- Reset asserted in the 3rd MUL cycle -> next cycle out_valid=0, in_ready=1, O=0, Zero=1, no result emitted. Sel=4'b1111 -> Illegal=1, O=0, Zero=1.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared types for the sequential arithmetic ALU: opcodes, FSM states and the flag bundle.
package ula_pkg;

  typedef enum logic [3:0] {
    OP_ADD      = 4'b0000,
    OP_SUB      = 4'b0001,
    OP_ADD_NOTB = 4'b0010,
    OP_SUB_NOTB = 4'b0011,
    OP_INC_A    = 4'b0100,
    OP_DEC_A    = 4'b0101,
    OP_INC_B    = 4'b0110,
    OP_DEC_B    = 4'b0111,
    OP_MUL      = 4'b1000,
    OP_NEG      = 4'b1001
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } st_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
    logic illegal;
  } flags_t;

  localparam flags_t FLAGS_RST = '{carry: 1'b0, overflow: 1'b0, zero: 1'b1,
                                   negative: 1'b0, illegal: 1'b0};

  // Opcodes above NEG are unassigned.
  function automatic logic is_illegal(input logic [3:0] sel);
    return (sel > OP_NEG);
  endfunction

endpackage

// File: rtl/ula_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, LSB first.
// Takes WIDTH busy cycles after start; o_done flags the last step with o_product valid.
module ula_mul_iter #(
  parameter int WIDTH = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end

  // Product is taken from the accumulator's next value so the caller can register it on the last step.
  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == LAST);
  assign o_product = w_acc_nxt;

endmodule

// File: rtl/ula_aritmetica_seq.sv
// Handshaked multi-cycle arithmetic ALU: add/sub/neg/inc/dec in one cycle, iterative MUL,
// optional saturation, result and flags held in registers until consumed.
//   state   | meaning
//   IDLE    | in_ready=1, waiting for a request
//   MUL     | iterative multiply in progress
//   DONE    | out_valid=1, result held until out_ready
module ula_aritmetica_seq
  import ula_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int SAT_EN = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Sel,
  input  logic             Sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero,
  output logic             Negative,
  output logic             Illegal
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Returns {carry, overflow, result} for every single-cycle opcode; zeros otherwise.
  function automatic logic [WIDTH+1:0] f_alu(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [3:0]       sel,
                                             input logic             sat);
    logic [WIDTH-1:0] x, y, r, opnd;
    logic [WIDTH:0]   sum;
    logic             cin, c, v, addsub;
    x = a; y = b; cin = 1'b0; addsub = 1'b1;
    r = '0; c = 1'b0; v = 1'b0; sum = '0;
    opnd = sel[1] ? b : a;
    case (sel)
      OP_ADD:      begin x = a;  y = b;  cin = 1'b0; end
      OP_SUB:      begin x = a;  y = ~b; cin = 1'b1; end
      OP_ADD_NOTB: begin x = a;  y = ~b; cin = 1'b0; end
      OP_SUB_NOTB: begin x = a;  y = b;  cin = 1'b1; end
      OP_NEG:      begin x = '0; y = ~a; cin = 1'b1; end
      default:     addsub = 1'b0;
    endcase
    if (addsub) begin
      sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
      r = sum[WIDTH-1:0];
      c = sum[WIDTH];
      v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      if (sat && v) r = x[WIDTH-1] ? SMIN : SMAX;
    end else if ((sel == OP_INC_A) || (sel == OP_INC_B)) begin
      c = &opnd;
      r = (sat && c) ? opnd : opnd + WIDTH'(1);
    end else if ((sel == OP_DEC_A) || (sel == OP_DEC_B)) begin
      c = (opnd == '0);
      r = (sat && c) ? opnd : opnd - WIDTH'(1);
    end
    return {c, v, r};
  endfunction

  st_e                r_state;
  logic [WIDTH-1:0]   r_o;
  flags_t             r_flags;
  logic               r_sat;

  logic               w_sat;
  logic               w_illegal;
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH+1:0]   w_alu;
  logic               w_load;
  logic [WIDTH-1:0]   w_o_nxt;
  logic               w_c_nxt;
  logic               w_v_nxt;
  logic               w_ill_nxt;

  assign w_sat       = (SAT_EN != 0) && Sat;
  assign w_illegal   = is_illegal(Sel);
  assign w_mul_start = (r_state == ST_IDLE) && in_valid && (Sel == OP_MUL);

  ula_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_start   (w_mul_start),
    .i_mcand   (A),
    .i_mplier  (B),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  always_comb begin
    w_alu     = f_alu(A, B, Sel, w_sat);
    w_load    = 1'b0;
    w_o_nxt   = '0;
    w_c_nxt   = 1'b0;
    w_v_nxt   = 1'b0;
    w_ill_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && (Sel != OP_MUL)) begin
          w_load                      = 1'b1;
          {w_c_nxt, w_v_nxt, w_o_nxt} = w_alu;
          w_ill_nxt                   = w_illegal;
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_load  = 1'b1;
          w_v_nxt = |w_prod[2*WIDTH-1:WIDTH];
          w_o_nxt = (r_sat && w_v_nxt) ? '1 : w_prod[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_o     <= '0;
      r_flags <= FLAGS_RST;
      r_sat   <= 1'b0;
    end else begin
      if (w_load) begin
        r_o              <= w_o_nxt;
        r_flags.carry    <= w_c_nxt;
        r_flags.overflow <= w_v_nxt;
        r_flags.zero     <= (w_o_nxt == '0);
        r_flags.negative <= w_o_nxt[WIDTH-1];
        r_flags.illegal  <= w_ill_nxt;
      end
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sat   <= w_sat;
            r_state <= (Sel == OP_MUL) ? ST_MUL : ST_DONE;
          end
        end
        ST_MUL: begin
          if (w_mul_done)       r_state <= ST_DONE;
          else if (!w_mul_busy) r_state <= ST_IDLE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign O         = r_o;
  assign Carry     = r_flags.carry;
  assign Overflow  = r_flags.overflow;
  assign Zero      = r_flags.zero;
  assign Negative  = r_flags.negative;
  assign Illegal   = r_flags.illegal;

endmodule

// File: tb/tb_ula_aritmetica_seq.sv
// Directed bench for ula_aritmetica_seq (WIDTH=6, SAT_EN=1) with hand-computed expectations.
module tb_ula_aritmetica_seq;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] A, B;
  logic [3:0] Sel;
  logic       Sat;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] O;
  logic       Carry, Overflow, Zero, Negative, Illegal;

  int n_checks = 0;
  int n_fail   = 0;

  ula_aritmetica_seq #(.WIDTH(6), .SAT_EN(1)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sel(Sel), .Sat(Sat), .out_valid(out_valid), .out_ready(out_ready),
    .O(O), .Carry(Carry), .Overflow(Overflow), .Zero(Zero), .Negative(Negative),
    .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Presents one request, then scrambles the inputs to prove they were captured.
  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input logic [3:0] sel,
                        input logic sat, output int lat);
    A = a; B = b; Sel = sel; Sat = sat; in_valid = 1'b1;
    chk("req_in_ready", in_ready, 1);
    @(posedge Clk); #1;
    in_valid = 1'b0; A = 6'h3f; B = 6'h3f; Sel = 4'b1010; Sat = ~sat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk("busy_in_ready", in_ready, 0);
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    chk("consumed_out_valid", out_valid, 0);
  endtask

  task automatic op_check(input string tag, input logic [5:0] a, input logic [5:0] b,
                          input logic [3:0] sel, input logic sat, input int exp_lat,
                          input logic [5:0] eo, input logic ec, input logic ev,
                          input logic ez, input logic en, input logic ei);
    int lat;
    run_op(a, b, sel, sat, lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_O"}, O, eo);
    chk({tag, "_C"}, Carry, ec);
    chk({tag, "_V"}, Overflow, ev);
    chk({tag, "_Z"}, Zero, ez);
    chk({tag, "_N"}, Negative, en);
    chk({tag, "_I"}, Illegal, ei);
    consume();
  endtask

  initial begin
    int lat;
    int seen;
    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Sel = '0; Sat = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;

    chk("rst_O", O, 0);
    chk("rst_Z", Zero, 1);
    chk("rst_C", Carry, 0);
    chk("rst_V", Overflow, 0);
    chk("rst_N", Negative, 0);
    chk("rst_I", Illegal, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);

    //          tag          A   B   Sel      Sat lat O   C V Z N I
    op_check("add",        30,  5, 4'b0000, 0, 1, 35, 0,1,0,1,0);
    op_check("add_sat",    30,  5, 4'b0000, 1, 1, 31, 0,1,0,0,0);
    op_check("sub_0m1",     0,  1, 4'b0001, 0, 1, 63, 0,0,0,1,0);
    op_check("sub_5m3",     5,  3, 4'b0001, 0, 1,  2, 1,0,0,0,0);
    op_check("sub_notb",    2,  3, 4'b0011, 0, 1,  6, 0,0,0,0,0);
    op_check("add_notb",    4,  1, 4'b0010, 0, 1,  2, 1,0,0,0,0);
    op_check("inc_wrap",   63,  0, 4'b0100, 0, 1,  0, 1,0,1,0,0);
    op_check("inc_clamp",  63,  0, 4'b0100, 1, 1, 63, 1,0,0,1,0);
    op_check("dec_b_clamp", 9,  0, 4'b0111, 1, 1,  0, 1,0,1,0,0);
    op_check("dec_a",      10,  0, 4'b0101, 0, 1,  9, 0,0,0,0,0);
    op_check("inc_b",       0, 20, 4'b0110, 0, 1, 21, 0,0,0,0,0);
    op_check("neg_5",       5,  0, 4'b1001, 0, 1, 59, 0,0,0,1,0);
    op_check("neg_0",       0,  0, 4'b1001, 0, 1,  0, 1,0,1,0,0);
    op_check("neg_min_sat",32,  0, 4'b1001, 1, 1, 31, 0,1,0,0,0);
    op_check("mul_8x8",     8,  8, 4'b1000, 0, 7,  0, 0,1,1,0,0);
    op_check("mul_8x8_sat", 8,  8, 4'b1000, 1, 7, 63, 0,1,0,1,0);
    op_check("mul_7x9",     7,  9, 4'b1000, 0, 7, 63, 0,0,0,1,0);

    // Backpressure: hold the result while the requester keeps pushing.
    run_op(6'd1, 6'd2, 4'b0000, 1'b0, lat);
    chk("bp_lat", lat, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = 6'(i * 11 + 5); B = 6'(i * 7 + 9); Sel = 4'(i);
      @(posedge Clk); #1;
      chk("bp_O", O, 3);
      chk("bp_flags", {Carry, Overflow, Zero, Negative, Illegal}, 5'b00000);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1; in_valid = 1'b1; A = 6'd40; B = 6'd1; Sel = 4'b0000;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_rel_out_valid", out_valid, 0);
    chk("bp_rel_O", O, 3);
    in_valid = 1'b0;

    // Reset during the third MUL cycle aborts the operation and clears the result.
    A = 6'd7; B = 6'd9; Sel = 4'b1000; Sat = 1'b0; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_O", O, 0);
    chk("mrst_Z", Zero, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (out_valid) seen++;
    end
    chk("mrst_no_result", seen, 0);

    op_check("illegal",    12, 34, 4'b1111, 1, 1,  0, 0,0,1,0,1);
    op_check("illegal_a",  63, 63, 4'b1010, 0, 1,  0, 0,0,1,0,1);
    op_check("after_ill",   1,  1, 4'b0000, 0, 1,  2, 0,0,0,0,0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
